snake_pixel_gen: RTL and testbench
==================================

// Module: snake_pixel_gen
// PURPOSE
// - Snake game engine and pixel colour source placed directly upstream of the VGA timing controller.
// - Consumes the controller's oCoord_X/oCoord_Y and oVGA_V_SYNC; drives the controller's iRed/iGreen/iBlue.
// - Holds snake and food state on a cell grid and advances the game once every MOVE_FRAMES frames.
// - Resolves direction input, growth, scoring, and wall/self collision.
// PARAMETERS
// - CELL_LOG2    4    cell edge = 2**CELL_LOG2 px (16 px gives a 40x30 grid at 640x480)
// - GRID_W       40   grid columns
// - GRID_H       30   grid rows
// - MAX_LEN      16   segment storage depth; length saturates here
// - MOVE_FRAMES  8    frames per snake step (>=1)
// PORTS
// - iCLK         in   1   pixel clock, same clock as the VGA controller
// - iRST         in   1   synchronous, active-high reset
// - iCoord_X     in   10  active-area pixel X from the VGA controller
// - iCoord_Y     in   10  active-area pixel Y from the VGA controller
// - iV_SYNC      in   1   VGA vertical sync (active low); its falling edge is the frame tick
// - iDir_Valid   in   1   one-cycle strobe qualifying iDir
// - iDir         in   2   0=up 1=right 2=down 3=left
// - iStart       in   1   restart request, honoured only in DEAD
// - oRed         out  10  pixel red
// - oGreen       out  10  pixel green
// - oBlue        out  10  pixel blue
// - oScore       out  8   food eaten since reset/restart, saturating at 255
// - oGame_Over   out  1   high while in DEAD
// BEHAVIOUR
// - Reset (sync, wins in every state):
//   - state=RUN; len=3; segments (20,15),(19,15),(18,15) with head first; dir=pend_dir=right.
//   - food=(30,15); frame_cnt=0; LFSR=16'hACE1.
//   - oRed/oGreen/oBlue=0; oScore=0; oGame_Over=0.
// - Frame tick: registered iV_SYNC is 1 and current iV_SYNC is 0 (one pulse per frame).
//   - In RUN, frame_cnt increments on each tick.
//   - At MOVE_FRAMES-1 the tick wraps frame_cnt to 0 and enters STEP.
// - Direction: on iDir_Valid, pend_dir<=iDir unless iDir is the exact opposite of dir (request ignored).
//   - The last valid strobe before STEP entry wins.
// - FSM RUN -> STEP -> CHECK -> RUN|DEAD; DEAD -> RUN on iStart (re-applies reset values except LFSR).
//   - STEP (1 cycle): dir<=pend_dir; compute new head = head +/-1 on x or y.
//     - Each cell coordinate is 1 bit wider than needed so that -1 and GRID_W/GRID_H are detectable.
//   - CHECK (1 cycle):
//     - Wall: new head x<0 or >=GRID_W, or y<0 or >=GRID_H -> DEAD with segments unchanged.
//     - Self: new head equals any old segment 0..len-2 -> DEAD. The old tail (index len-1) is vacating and is not a hit.
//     - Otherwise shift segments (seg[i]<=seg[i-1]) and set seg[0]<=new head.
//     - If new head==food: len<=min(len+1,MAX_LEN); the old tail is kept as the new last segment; oScore++ (saturating); food<=LFSR cell.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11; steps every cycle.
//   - Food x = L[5:0]>=GRID_W ? L[5:0]-24 : L[5:0].
//   - Food y = L[10:6]>=GRID_H ? L[10:6]-2 : L[10:6].
//   - Food may land on the body; this is legal.
// - Pixel path: cell = coord>>CELL_LOG2. Output is registered with 1-cycle latency from iCoord_*. Priority:
//   - head: 0,3FF,0
//   - body seg 1..len-1: 0,200,0
//   - food: 3FF,0,0
//   - otherwise: 0,0,80
//   - In DEAD, the red channel of every pixel is forced to 3FF.
// - Segment registers at index >=len are don't-care and never drive colour.
// CONFIGURATION
// - SNAKE_GRID_EN defined: pixels with coord[CELL_LOG2-1:0]==0 on x or y get 100,100,100.
//   - This is inserted between the food and background priorities.
// - SNAKE_GRID_EN undefined: no grid logic is generated; the background is uniform.
// TESTING
// - Reset, then sweep coord (320,240),(304,240),(480,240),(0,0).
//   - Expect head 0/3FF/0, body 0/200/0, food 3FF/0/0, background 0/0/80, all one cycle later.
// - Apply 8 V_SYNC falling edges with no direction input.
//   - Expect head (21,15) and tail (19,15) after CHECK.
//   - After 7 edges, state is unchanged.
// - Strobe iDir=3 (reverse) then 8 frames: head (21,15), request ignored.
//   - Strobe iDir=0 then 8 frames: head (20,14).
// - Run right from reset for 20 steps.
//   - Expect oGame_Over=1 when head x would be 40, head frozen at (39,15), all pixels red=3FF.
//   - iStart then restores the reset layout.
// - After 10 steps right the head reaches food (30,15).
//   - Expect len=4, oScore=1, food moved to the LFSR cell.
//   - Assert iRST during CHECK: all reset values the next cycle.
// - With SNAKE_GRID_EN, pixel (32,7) is 100/100/100; without it, 0/0/80.

Source files
------------

// File: rtl/snake_pixel_gen.sv
// snake_pixel_gen: snake game engine and pixel colour source ahead of the VGA controller.
// Optional: define SNAKE_GRID_EN to draw cell grid lines on the background.
module snake_pixel_gen #(
    parameter int CELL_LOG2   = 4,
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int MAX_LEN     = 16,
    parameter int MOVE_FRAMES = 8
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    input  logic       iV_SYNC,
    input  logic       iDir_Valid,
    input  logic [1:0] iDir,
    input  logic       iStart,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic [7:0] oScore,
    output logic       oGame_Over
);
    localparam int XW = $clog2(GRID_W) + 1;
    localparam int YW = $clog2(GRID_H) + 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int FW = $clog2(MOVE_FRAMES + 1);

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] LEFT  = 2'd3;

    typedef enum logic [1:0] {RUN, STEP, CHECK, DEAD} state_t;

    state_t        state;
    logic [XW-1:0] segX [MAX_LEN];
    logic [YW-1:0] segY [MAX_LEN];
    logic [LW-1:0] len;
    logic [1:0]    dir;
    logic [1:0]    pendDir;
    logic [XW-1:0] foodX;
    logic [YW-1:0] foodY;
    logic [XW-1:0] nhX;
    logic [YW-1:0] nhY;
    logic [FW-1:0] frameCnt;
    logic [15:0]   lfsr;
    logic          vsPrev;

    logic          tick;
    logic          doInit;
    logic          wallHit;
    logic          selfHit;
    logic          eat;
    logic [5:0]    lfsrX;
    logic [4:0]    lfsrY;
    logic [XW-1:0] newFoodX;
    logic [YW-1:0] newFoodY;

    assign tick   = vsPrev & ~iV_SYNC;
    assign doInit = iRST | (state == DEAD && iStart);

    // Fold out-of-range LFSR fields back onto the grid.
    assign lfsrX    = lfsr[5:0];
    assign lfsrY    = lfsr[10:6];
    assign newFoodX = XW'(lfsrX >= 6'(GRID_W) ? lfsrX - 6'(64 - GRID_W) : lfsrX);
    assign newFoodY = YW'(lfsrY >= 5'(GRID_H) ? lfsrY - 5'(32 - GRID_H) : lfsrY);

    // Off-grid heads wrap to large unsigned values, so one compare covers -1.
    assign wallHit = (nhX >= XW'(GRID_W)) || (nhY >= YW'(GRID_H));
    assign eat     = (nhX == foodX) && (nhY == foodY);

    always_comb begin
        selfHit = 1'b0;
        for (int i = 0; i < MAX_LEN - 1; i++) begin
            if (LW'(i + 1) < len && segX[i] == nhX && segY[i] == nhY)
                selfHit = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vsPrev <= 1'b0;
            lfsr   <= 16'hACE1;
        end else begin
            vsPrev <= iV_SYNC;
            lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_ff @(posedge iCLK) begin
        if (doInit) begin
            state      <= RUN;
            len        <= LW'(3);
            for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= '0;
                segY[i] <= '0;
            end
            segX[0]    <= XW'(20);
            segX[1]    <= XW'(19);
            segX[2]    <= XW'(18);
            segY[0]    <= YW'(15);
            segY[1]    <= YW'(15);
            segY[2]    <= YW'(15);
            dir        <= RIGHT;
            pendDir    <= RIGHT;
            foodX      <= XW'(30);
            foodY      <= YW'(15);
            nhX        <= '0;
            nhY        <= '0;
            frameCnt   <= '0;
            oScore     <= 8'd0;
            oGame_Over <= 1'b0;
        end else begin
            if (iDir_Valid && state != STEP && iDir != (dir ^ 2'd2))
                pendDir <= iDir;
            unique case (state)
                RUN: begin
                    if (tick) begin
                        if (frameCnt == FW'(MOVE_FRAMES - 1)) begin
                            frameCnt <= '0;
                            state    <= STEP;
                        end else begin
                            frameCnt <= frameCnt + FW'(1);
                        end
                    end
                end
                STEP: begin
                    dir   <= pendDir;
                    state <= CHECK;
                    unique case (1'b1)
                        pendDir == UP: begin
                            nhX <= segX[0];
                            nhY <= segY[0] - YW'(1);
                        end
                        pendDir == RIGHT: begin
                            nhX <= segX[0] + XW'(1);
                            nhY <= segY[0];
                        end
                        pendDir == DOWN: begin
                            nhX <= segX[0];
                            nhY <= segY[0] + YW'(1);
                        end
                        pendDir == LEFT: begin
                            nhX <= segX[0] - XW'(1);
                            nhY <= segY[0];
                        end
                    endcase
                end
                CHECK: begin
                    if (wallHit || selfHit) begin
                        state      <= DEAD;
                        oGame_Over <= 1'b1;
                    end else begin
                        state <= RUN;
                        for (int i = MAX_LEN - 1; i > 0; i--) begin
                            segX[i] <= segX[i-1];
                            segY[i] <= segY[i-1];
                        end
                        segX[0] <= nhX;
                        segY[0] <= nhY;
                        // Growth keeps the shifted-out tail by bumping len.
                        if (eat) begin
                            if (len != LW'(MAX_LEN))
                                len <= len + LW'(1);
                            if (oScore != 8'hFF)
                                oScore <= oScore + 8'd1;
                            foodX <= newFoodX;
                            foodY <= newFoodY;
                        end
                    end
                end
                DEAD: begin
                end
            endcase
        end
    end

    logic [9:0]  cellX;
    logic [9:0]  cellY;
    logic        headPix;
    logic        bodyPix;
    logic        foodPix;
    logic [29:0] pixRgb;

    always_comb begin
        cellX   = iCoord_X >> CELL_LOG2;
        cellY   = iCoord_Y >> CELL_LOG2;
        headPix = (cellX == 10'(segX[0])) && (cellY == 10'(segY[0]));
        foodPix = (cellX == 10'(foodX)) && (cellY == 10'(foodY));
        bodyPix = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LW'(i) < len && cellX == 10'(segX[i]) && cellY == 10'(segY[i]))
                bodyPix = 1'b1;
        end
    end

`ifdef SNAKE_GRID_EN
    logic gridPix;
    assign gridPix = (iCoord_X[CELL_LOG2-1:0] == '0) ||
                     (iCoord_Y[CELL_LOG2-1:0] == '0);
`endif

    always_comb begin
        if (headPix)
            pixRgb = {10'h000, 10'h3FF, 10'h000};
        else if (bodyPix)
            pixRgb = {10'h000, 10'h200, 10'h000};
        else if (foodPix)
            pixRgb = {10'h3FF, 10'h000, 10'h000};
`ifdef SNAKE_GRID_EN
        else if (gridPix)
            pixRgb = {10'h100, 10'h100, 10'h100};
`endif
        else
            pixRgb = {10'h000, 10'h000, 10'h080};
        if (state == DEAD)
            pixRgb[29:20] = 10'h3FF;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else begin
            oRed   <= pixRgb[29:20];
            oGreen <= pixRgb[19:10];
            oBlue  <= pixRgb[9:0];
        end
    end
endmodule

// File: tb/tb_snake_pixel_gen.sv
// tb_snake_pixel_gen: randomized bench with a queue-based game model and per-cycle compare.
module tb_snake_pixel_gen;
    localparam int CELL = 16;
    localparam int GW   = 40;
    localparam int GH   = 30;
    localparam int MAXL = 16;
    localparam int MF   = 8;

    localparam logic [29:0] HEADC = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] BODYC = {10'h000, 10'h200, 10'h000};
    localparam logic [29:0] FOODC = {10'h3FF, 10'h000, 10'h000};
    localparam logic [29:0] BGC   = {10'h000, 10'h000, 10'h080};
    localparam logic [29:0] GRIDC = {10'h100, 10'h100, 10'h100};

    logic       clk;
    logic       iRST;
    logic [9:0] iCoord_X;
    logic [9:0] iCoord_Y;
    logic       iV_SYNC;
    logic       iDir_Valid;
    logic [1:0] iDir;
    logic       iStart;
    logic [9:0] oRed;
    logic [9:0] oGreen;
    logic [9:0] oBlue;
    logic [7:0] oScore;
    logic       oGame_Over;

    snake_pixel_gen dut (
        .iCLK       (clk),
        .iRST       (iRST),
        .iCoord_X   (iCoord_X),
        .iCoord_Y   (iCoord_Y),
        .iV_SYNC    (iV_SYNC),
        .iDir_Valid (iDir_Valid),
        .iDir       (iDir),
        .iStart     (iStart),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oScore     (oScore),
        .oGame_Over (oGame_Over)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int printed  = 0;

    // Game model: snake is a queue of cells, head first.
    int          sx[$];
    int          sy[$];
    int          fx, fy, mdir, mpend, mscore, mfc, stepIn;
    bit          mdead;
    bit          prevVs;
    bit          mStarted = 0;
    logic [15:0] ml;
    logic [9:0]  eR, eG, eB;
    int          oldDir;
    bit          wasStep, restartNow, mtick;

    function automatic logic [15:0] lstep(logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic mInit();
        sx.delete();
        sy.delete();
        for (int i = 0; i < 3; i++) begin
            sx.push_back(20 - i);
            sy.push_back(15);
        end
        fx = 30; fy = 15;
        mdir = 1; mpend = 1;
        mscore = 0; mfc = 0; stepIn = 0; mdead = 0;
    endtask

    task automatic mColour(input int x, input int y,
                           output logic [9:0] r, output logic [9:0] g,
                           output logic [9:0] b);
        int cx, cy;
        cx = x / CELL;
        cy = y / CELL;
        {r, g, b} = BGC;
`ifdef SNAKE_GRID_EN
        if (x % CELL == 0 || y % CELL == 0) {r, g, b} = GRIDC;
`endif
        if (cx == fx && cy == fy) {r, g, b} = FOODC;
        for (int i = sx.size() - 1; i >= 1; i--)
            if (sx[i] == cx && sy[i] == cy) {r, g, b} = BODYC;
        if (sx[0] == cx && sy[0] == cy) {r, g, b} = HEADC;
        if (mdead) r = 10'h3FF;
    endtask

    task automatic mMove();
        int nx, ny;
        bit hit;
        nx = sx[0];
        ny = sy[0];
        case (mdir)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        hit = (nx < 0 || nx >= GW || ny < 0 || ny >= GH);
        for (int i = 0; i < sx.size() - 1; i++)
            if (sx[i] == nx && sy[i] == ny) hit = 1;
        if (hit) begin
            mdead = 1;
        end else begin
            sx.push_front(nx);
            sy.push_front(ny);
            if (nx == fx && ny == fy) begin
                if (mscore < 255) mscore++;
                fx = int'(ml[5:0]);
                if (fx >= GW) fx = fx - 24;
                fy = int'(ml[10:6]);
                if (fy >= GH) fy = fy - 2;
                if (sx.size() > MAXL) begin
                    void'(sx.pop_back());
                    void'(sy.pop_back());
                end
            end else begin
                void'(sx.pop_back());
                void'(sy.pop_back());
            end
        end
    endtask

    always @(posedge clk) begin
        if (iRST) begin
            mInit();
            ml = 16'hACE1;
            prevVs = 0;
            {eR, eG, eB} = '0;
        end else begin
            mColour(int'(iCoord_X), int'(iCoord_Y), eR, eG, eB);
            mtick = prevVs && !iV_SYNC;
            prevVs = iV_SYNC;
            oldDir = mdir;
            wasStep = (stepIn == 2);
            restartNow = 0;
            if (stepIn == 2) begin
                mdir = mpend;
                stepIn = 1;
            end else if (stepIn == 1) begin
                mMove();
                stepIn = 0;
            end else if (mdead) begin
                if (iStart) begin
                    mInit();
                    restartNow = 1;
                end
            end else if (mtick) begin
                if (mfc == MF - 1) begin
                    mfc = 0;
                    stepIn = 2;
                end else begin
                    mfc++;
                end
            end
            if (iDir_Valid && !wasStep && !restartNow && int'(iDir) != (oldDir ^ 2))
                mpend = int'(iDir);
            ml = lstep(ml);
        end
        mStarted = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    bit randCoord = 1;

    task automatic step1();
        int k;
        @(negedge clk);
        if (mStarted) begin
            checks++;
            if ({oRed, oGreen, oBlue, oScore, oGame_Over} !==
                {eR, eG, eB, 8'(mscore), mdead}) begin
                failures++;
                if (printed < 20)
                    $display("FAIL cycle t=%0t got rgb=%h/%h/%h score=%0d go=%0b want rgb=%h/%h/%h score=%0d go=%0b",
                             $time, oRed, oGreen, oBlue, oScore, oGame_Over,
                             eR, eG, eB, mscore, mdead);
                printed++;
            end
        end
        if (randCoord && sx.size() > 0) begin
            k = int'($urandom_range(0, 3));
            if (k == 0) begin
                iCoord_X = 10'(sx[0] * CELL + int'($urandom_range(0, 15)));
                iCoord_Y = 10'(sy[0] * CELL + int'($urandom_range(0, 15)));
            end else if (k == 1) begin
                iCoord_X = 10'(fx * CELL + int'($urandom_range(0, 15)));
                iCoord_Y = 10'(fy * CELL + int'($urandom_range(0, 15)));
            end else if (k == 2) begin
                iCoord_X = 10'($urandom_range(0, 639));
                iCoord_Y = 10'($urandom_range(224, 255));
            end else begin
                iCoord_X = 10'($urandom_range(0, 639));
                iCoord_Y = 10'($urandom_range(0, 479));
            end
        end
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            iV_SYNC = 0;
            step1();
            step1();
            iV_SYNC = 1;
            for (int c = 0; c < 6; c++) step1();
        end
    endtask

    task automatic strobe(input int d);
        iDir_Valid = 1;
        iDir = 2'(d);
        step1();
        iDir_Valid = 0;
    endtask

    task automatic doReset();
        iRST = 1;
        iV_SYNC = 1;
        step1();
        iRST = 0;
        step1();
    endtask

    task automatic pix(input string name, input int x, input int y, input logic [29:0] exp);
        iCoord_X = 10'(x);
        iCoord_Y = 10'(y);
        step1();
        chk(name, {2'b00, oRed, oGreen, oBlue}, {2'b00, exp});
    endtask

    initial begin
        clk = 0;
        iRST = 1;
        iV_SYNC = 1;
        iDir_Valid = 0;
        iDir = 0;
        iStart = 0;
        iCoord_X = 0;
        iCoord_Y = 0;
        step1();
        step1();
        chk("rst_red", 32'(oRed), 0);
        chk("rst_score", 32'(oScore), 0);
        chk("rst_gameover", 32'(oGame_Over), 0);
        iRST = 0;
        step1();

        pix("pix_head", 320, 240, HEADC);
        pix("pix_body", 304, 240, BODYC);
        pix("pix_food", 480, 240, FOODC);
`ifdef SNAKE_GRID_EN
        pix("pix_origin", 0, 0, GRIDC);
        pix("pix_grid", 32, 7, GRIDC);
`else
        pix("pix_origin", 0, 0, BGC);
        pix("pix_grid", 32, 7, BGC);
`endif

        frames(7);
        pix("seven_frames_head", 320, 240, HEADC);
        chk("model_head7", 32'(sx[0]), 20);
        frames(1);
        pix("step_head", 336, 240, HEADC);
        pix("step_tail", 304, 240, BODYC);
        pix("step_vacated", 296, 248, BGC);
        chk("model_head8", 32'(sx[0]), 21);

        doReset();
        strobe(3);
        frames(8);
        pix("reverse_ignored", 336, 240, HEADC);
        doReset();
        strobe(0);
        frames(8);
        pix("turn_up", 320, 224, HEADC);
        chk("model_up_y", 32'(sy[0]), 14);

        doReset();
        frames(80);
        chk("eat_score", 32'(oScore), 1);
        chk("model_len", 32'(sx.size()), 4);
        frames(72);
        chk("alive_at_39", 32'(oGame_Over), 0);
        chk("model_head39", 32'(sx[0]), 39);
        frames(8);
        chk("wall_dead", 32'(oGame_Over), 1);
        pix("dead_head", 624, 240, {10'h3FF, 10'h3FF, 10'h000});
        iCoord_X = 8;
        iCoord_Y = 8;
        step1();
        chk("dead_red", 32'(oRed), 32'h3FF);
        iStart = 1;
        step1();
        iStart = 0;
        pix("restart_head", 320, 240, HEADC);
        chk("restart_go", 32'(oGame_Over), 0);
        chk("restart_score", 32'(oScore), 0);

        doReset();
        frames(79);
        iV_SYNC = 0;
        step1();
        step1();
        iRST = 1;
        step1();
        chk("rst_in_check_score", 32'(oScore), 0);
        chk("rst_in_check_rgb", {2'b00, oRed, oGreen, oBlue}, 0);
        iRST = 0;
        iV_SYNC = 1;
        step1();
        pix("rst_in_check_head", 320, 240, HEADC);

        doReset();
        for (int f = 0; f < 300; f++) begin
            if (mdead) begin
                iStart = 1;
                step1();
                iStart = 0;
            end
            if ($urandom_range(0, 1) == 1) strobe(int'($urandom_range(0, 3)));
            frames(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
